// File: rtl/fa_ha.sv
// Full adder built from two half adders, with a registered copy of the
// result, a saturating carry counter and a sticky self-check flag.

// Single-bit half adder: sum and carry of two bits.
module fa_ha_half (
    input  logic x,
    input  logic y,
    output logic sum,
    output logic carry
);

    assign sum   = x ^ y;
    assign carry = x & y;

endmodule

module fa_ha (
    input  logic       clk,
    input  logic       rst,
    input  logic       a,
    input  logic       b,
    input  logic       ci,
    output logic       s,
    output logic       co,
    output logic       s_q,
    output logic       co_q,
    output logic       q_valid,
    output logic [7:0] carry_cnt,
    output logic       mismatch
);

    localparam logic [7:0] CNT_MAX = 8'hFF;

    logic       p;
    logic       g1;
    logic       g2;

    logic [1:0] ref_sum;
    logic       ref_err;

    logic       sum_q;
    logic       sum_d;
    logic       cout_q;
    logic       cout_d;
    logic       vld_q;
    logic       vld_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       err_q;
    logic       err_d;

    // First stage: propagate and generate from the two addend bits.
    fa_ha_half u_ha1 (
        .x     (a),
        .y     (b),
        .sum   (p),
        .carry (g1)
    );

    // Second stage: fold in the carry-in to form the final sum.
    fa_ha_half u_ha2 (
        .x     (p),
        .y     (ci),
        .sum   (s),
        .carry (g2)
    );

    assign co = g1 | g2;

    // Behavioral reference: popcount of the three input bits.
    always_comb begin
        ref_sum = {1'b0, a} + {1'b0, b} + {1'b0, ci};
        ref_err = 1'b0;
        if (ref_sum != {co, s}) begin
            ref_err = 1'b1;
        end
    end

    // Next-state: capture the adder result and update counter/flag.
    always_comb begin
        sum_d  = s;
        cout_d = co;
        vld_d  = 1'b1;
        cnt_d  = cnt_q;
        err_d  = err_q | ref_err;
        if (co && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // State registers, cleared immediately on reset assertion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= 1'b0;
            cout_q <= 1'b0;
            vld_q  <= 1'b0;
            cnt_q  <= 8'd0;
            err_q  <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            vld_q  <= vld_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign s_q       = sum_q;
    assign co_q      = cout_q;
    assign q_valid   = vld_q;
    assign carry_cnt = cnt_q;
    assign mismatch  = err_q;

endmodule

// File: tb/tb_fa_ha.sv
// Directed testbench for fa_ha: combinational sweep, registered latency,
// counter saturation, asynchronous reset and mixed carry sequence.
module tb_fa_ha;

    logic       clk;
    logic       rst;
    logic       a;
    logic       b;
    logic       ci;
    logic       s;
    logic       co;
    logic       s_q;
    logic       co_q;
    logic       q_valid;
    logic [7:0] carry_cnt;
    logic       mismatch;

    int errors;
    int checks;

    fa_ha dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .s         (s),
        .co        (co),
        .s_q       (s_q),
        .co_q      (co_q),
        .q_valid   (q_valid),
        .carry_cnt (carry_cnt),
        .mismatch  (mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] v);
        {a, b, ci} = v;
    endtask

    logic [2:0] sweep_in  [8];
    logic [1:0] sweep_exp [8];

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        drive(3'b000);

        sweep_in  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        sweep_exp = '{2'b01, 2'b01, 2'b10, 2'b01,
                      2'b10, 2'b10, 2'b11, 2'b00};

        #3;
        chk("rst_s_q",       {7'd0, s_q},     8'd0);
        chk("rst_co_q",      {7'd0, co_q},    8'd0);
        chk("rst_q_valid",   {7'd0, q_valid}, 8'd0);
        chk("rst_carry_cnt", carry_cnt,       8'd0);
        chk("rst_mismatch",  {7'd0, mismatch}, 8'd0);

        // Combinational sweep, run during reset.
        for (int i = 0; i < 8; i++) begin
            drive(sweep_in[i]);
            #1;
            chk($sformatf("comb_%0d", sweep_in[i]),
                {6'd0, co, s}, {6'd0, sweep_exp[i]});
            #9;
        end

        // Registered latency: 111 applied before the first live edge.
        @(negedge clk);
        rst = 1'b0;
        drive(3'b111);
        #1;
        chk("lat_pre_valid", {7'd0, q_valid}, 8'd0);
        chk("lat_pre_s_q",   {7'd0, s_q},     8'd0);
        tick();
        chk("lat_s_q",     {7'd0, s_q},     8'd1);
        chk("lat_co_q",    {7'd0, co_q},    8'd1);
        chk("lat_q_valid", {7'd0, q_valid}, 8'd1);
        chk("lat_cnt",     carry_cnt,       8'd1);

        // Clocked sweep of all combinations; four of them carry.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(sweep_in[i]);
            tick();
            chk($sformatf("reg_%0d", sweep_in[i]),
                {6'd0, co_q, s_q}, {6'd0, sweep_exp[i]});
        end
        chk("sweep_cnt",      carry_cnt,        8'd5);
        chk("sweep_mismatch", {7'd0, mismatch}, 8'd0);

        // Counter saturation with 110 held for 300 cycles.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst2_cnt", carry_cnt, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(3'b110);
        for (int i = 0; i < 254; i++) tick();
        chk("sat_254", carry_cnt, 8'd254);
        tick();
        chk("sat_255", carry_cnt, 8'd255);
        for (int i = 0; i < 45; i++) tick();
        chk("sat_hold", carry_cnt, 8'd255);

        // Asynchronous reset between edges with count at 20.
        @(negedge clk);
        rst = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("ar_cnt20", carry_cnt, 8'd20);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_cnt",      carry_cnt,       8'd0);
        chk("ar_q_valid",  {7'd0, q_valid}, 8'd0);
        chk("ar_s_q",      {7'd0, s_q},     8'd0);
        chk("ar_co_q",     {7'd0, co_q},    8'd0);
        chk("ar_comb_110", {6'd0, co, s},   8'd2);
        drive(3'b111);
        #1;
        chk("ar_comb_111", {6'd0, co, s},   8'd3);

        // Mixed carries after reset release.
        @(negedge clk);
        rst = 1'b0;
        drive(3'b011);
        tick();
        chk("mix_fresh", {6'd0, co_q, s_q}, 8'd2);
        chk("mix_cnt1",  carry_cnt,         8'd1);
        @(negedge clk);
        drive(3'b000);
        tick();
        @(negedge clk);
        drive(3'b101);
        tick();
        @(negedge clk);
        drive(3'b001);
        tick();
        @(negedge clk);
        drive(3'b111);
        tick();
        chk("mix_cnt",      carry_cnt,        8'd3);
        chk("mix_s_q",      {7'd0, s_q},      8'd1);
        chk("mix_co_q",     {7'd0, co_q},     8'd1);
        chk("mix_mismatch", {7'd0, mismatch}, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fa_ha.md
FA_HA -- requirements
Module: fa_ha

Interface
REQ-001 Ports SHALL be, one clock domain; reset is asynchronous and active-high:
- clk  input  1  rising-edge clock for all registered logic
- rst  input  1  asynchronous active-high reset
- a  input  1  addend bit
- b  input  1  addend bit
- ci  input  1  carry-in bit
- s  output  1  combinational sum
- co  output  1  combinational carry-out
- s_q  output  1  registered sum
- co_q  output  1  registered carry-out
- q_valid  output  1  registered outputs hold a sampled result
- carry_cnt  output  8  saturating count of cycles with co=1
- mismatch  output  1  sticky self-check error flag
REQ-002 The module SHALL have no parameters.

Function
REQ-003 The s/co path SHALL be two half-adder instances plus an OR gate:
- HA1: p = a^b, g1 = a&b
- HA2: s = p^ci, g2 = p&ci
- co = g1 | g2
REQ-004 The half adder SHALL be a separate submodule (inputs x, y; outputs sum = x^y, carry = x&y), instantiated exactly twice.
REQ-005 s and co SHALL be purely combinational, with zero clock latency; they SHALL settle within the same simulation time step as an input change.
REQ-006 {co,s} SHALL equal a+b+ci for all 8 input combinations:
- 000 -> co=0 s=0
- 001, 010, 100 -> co=0 s=1
- 011, 101, 110 -> co=1 s=0
- 111 -> co=1 s=1
REQ-007 On each rising clk edge with rst low:
- s_q <= s
- co_q <= co
- q_valid <= 1
Registered-path latency SHALL be 1 cycle.
REQ-008 On each rising clk edge with rst low and co=1, carry_cnt SHALL increment by 1. At 8'hFF it SHALL saturate: hold 255, no wrap.
REQ-009 An independent behavioral reference SHALL compute {a,b,ci} popcount as a 2-bit value. If that value differs from {co,s} at a rising clk edge, mismatch SHALL be set to 1 and held until reset.
REQ-010 Inputs a, b, ci SHALL be treated as synchronous to clk for the registered path. Inputs X/Z SHALL propagate per normal Verilog semantics; no special handling.

Reset
REQ-011 While rst=1, regardless of clk:
- s_q=0
- co_q=0
- q_valid=0
- carry_cnt=0
- mismatch=0
REQ-012 Reset SHALL take effect immediately on assertion and SHALL NOT wait for a clock edge.
REQ-013 s and co SHALL remain combinationally valid during reset.
REQ-014 Reset asserted mid-operation SHALL discard the counter and flag state. The first rising edge after deassertion SHALL register fresh values.

Verification
REQ-015 Exhaustive combinational sweep: {a,b,ci} = 1..7, then 0, 10 ns apart -> {co,s} = 01,01,10,01,10,10,11,00 respectively, checked before each change.
REQ-016 Registered latency: rst released, {a,b,ci}=3'b111 applied before edge N -> s_q=1, co_q=1, q_valid=1 visible after edge N; unchanged before edge N.
REQ-017 Carry counter: hold {a,b,ci}=3'b110 for 300 cycles -> carry_cnt reaches 255 after 255 edges and stays 255.
REQ-018 Async reset: assert rst between clock edges with carry_cnt=20 -> carry_cnt=0, q_valid=0, s_q=co_q=0 immediately; s/co still track inputs.
REQ-019 Self-check: run the full 8-combination sweep over clocked cycles -> mismatch stays 0.
REQ-020 Mixed carries: sequence 011, 000, 101, 001, 111 over 5 edges -> carry_cnt=3, and final s_q=1, co_q=1.
